// File: rtl/move_request_gen_if.sv
// Button-to-move-pulse bus: raw buttons in, debounced levels
// and one-hot move flags out.
interface move_request_gen_if;
  logic [3:0] btnIn;
  logic [3:0] OffsetFlag;
  logic [3:0] btnLevel;
  logic       busy;

  modport master (
    output btnIn,
    input  OffsetFlag, btnLevel, busy
  );

  modport slave (
    input  btnIn,
    output OffsetFlag, btnLevel, busy
  );
endinterface

// File: rtl/move_request_gen.sv
// Debounced, auto-repeating push-button move request generator
// issuing serialised one-hot pulses to the offset handler.
module move_request_gen #(
  parameter int DEB_CYCLES = 250000,
  parameter int REP_DELAY  = 12500000,
  parameter int REP_PERIOD = 2500000,
  parameter int PULSE_LEN  = 2
) (
  input logic clk,
  input logic reset,
  move_request_gen_if.slave bus
);
  localparam int DW   = $clog2(DEB_CYCLES + 1);
  localparam int RMAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);
  localparam int PW   = (PULSE_LEN > 1) ? $clog2(PULSE_LEN + 1) : 1;

  typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

  logic [3:0]    sync1, sync2, lvl, lvlPrev, pending;
  logic [DW-1:0] debCnt [4];
  logic [RW-1:0] repCnt [4];
  logic [3:0]    repPhase, repFire, rise, conflict, req, grant;
  state_t        state, stateNext;
  logic [PW-1:0] pulseCnt;
  logic [1:0]    rrPtr, pickIdx, idx;
  logic          found;
  logic [3:0]    flagQ, flagNext;

  assign conflict = {{2{lvl[3] & lvl[2]}}, {2{lvl[1] & lvl[0]}}};
  assign rise     = lvl & ~lvlPrev;
  assign req      = (rise | repFire) & ~conflict;

  always_comb begin
    repFire = '0;
    for (int i = 0; i < 4; i++) begin
      repFire[i] = lvl[i] & ~conflict[i] & ~rise[i] &
                   (repPhase[i] ? (repCnt[i] == RW'(REP_PERIOD - 1))
                                : (repCnt[i] == RW'(REP_DELAY - 1)));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1    <= '0;
      sync2    <= '0;
      lvl      <= '0;
      lvlPrev  <= '0;
      repPhase <= '0;
      pending  <= '0;
      for (int i = 0; i < 4; i++) begin
        debCnt[i] <= '0;
        repCnt[i] <= '0;
      end
    end else begin
      sync1   <= bus.btnIn;
      sync2   <= sync1;
      lvlPrev <= lvl;
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == lvl[i]) begin
          debCnt[i] <= '0;
        end else if (debCnt[i] == DW'(DEB_CYCLES)) begin
          lvl[i]    <= ~lvl[i];
          debCnt[i] <= '0;
        end else begin
          debCnt[i] <= debCnt[i] + 1'b1;
        end
        // Timer restarts on edge, fire, release or pair conflict
        if (!lvl[i] || conflict[i] || rise[i] || repFire[i]) begin
          repCnt[i]   <= '0;
          repPhase[i] <= repFire[i];
        end else begin
          repCnt[i] <= repCnt[i] + 1'b1;
        end
      end
      pending <= (pending | req) & ~grant & ~conflict;
    end
  end

  always_comb begin
    found   = 1'b0;
    pickIdx = rrPtr;
    idx     = rrPtr;
    for (int i = 0; i < 4; i++) begin
      idx = rrPtr + 2'(i);
      if (!found && pending[idx]) begin
        found   = 1'b1;
        pickIdx = idx;
      end
    end
  end

  always_comb begin
    stateNext = state;
    flagNext  = flagQ;
    grant     = '0;
    unique case (state)
      IDLE: begin
        if (found) begin
          grant[pickIdx] = 1'b1;
          flagNext       = 4'(1) << pickIdx;
          stateNext      = PULSE;
        end
      end
      PULSE: begin
        if (pulseCnt == PW'(PULSE_LEN - 1)) begin
          flagNext  = '0;
          stateNext = GAP;
        end
      end
      GAP: begin
        if (pulseCnt == PW'(PULSE_LEN - 1)) stateNext = IDLE;
      end
      default: begin
        flagNext  = '0;
        stateNext = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      flagQ    <= '0;
      pulseCnt <= '0;
      rrPtr    <= '0;
    end else begin
      state <= stateNext;
      flagQ <= flagNext;
      if (state == IDLE || stateNext != state) pulseCnt <= '0;
      else pulseCnt <= pulseCnt + 1'b1;
      if (grant != '0) rrPtr <= pickIdx + 2'd1;
    end
  end

  assign bus.OffsetFlag = flagQ;
  assign bus.btnLevel   = lvl;
  assign bus.busy       = (state != IDLE);
endmodule

// File: tb/tb_move_request_gen.sv
// Directed bench for move_request_gen: vector tables plus
// multi-cycle sequences for reset, repeat and conflict cases.
module tb_move_request_gen;
  localparam int DEB = 4;
  localparam int RD  = 20;
  localparam int RP  = 8;
  localparam int PL  = 2;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  move_request_gen_if bus ();

  move_request_gen #(
    .DEB_CYCLES(DEB),
    .REP_DELAY (RD),
    .REP_PERIOD(RP),
    .PULSE_LEN (PL)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic [3:0] btn;
    logic [3:0] flag;
    logic [3:0] lvl;
    logic       busy;
  } vec_t;

  vec_t vq[$];
  int   nCmp = 0;
  int   nBad = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, int cyc, logic [3:0] act, logic [3:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s cyc=%0d got=%b want=%b", name, cyc, act, exp);
    end
  endtask

  task automatic chkInt(string name, int act, int exp);
    nCmp++;
    if (act != exp) begin
      nBad++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic doReset();
    bus.btnIn = '0;
    reset     = 1'b0;
    repeat (3) @(posedge clk);
    #3 reset = 1'b1;
  endtask

  task automatic add(logic [3:0] b, logic [3:0] f, logic [3:0] l, logic y);
    vec_t v;
    v.btn  = b;
    v.flag = f;
    v.lvl  = l;
    v.busy = y;
    vq.push_back(v);
  endtask

  task automatic runTable(string name);
    for (int n = 0; n < vq.size(); n++) begin
      bus.btnIn = vq[n].btn;
      tick();
      chk({name, ".flag"}, n, bus.OffsetFlag, vq[n].flag);
      chk({name, ".lvl"}, n, bus.btnLevel, vq[n].lvl);
      chk({name, ".busy"}, n, {3'b0, bus.busy}, {3'b0, vq[n].busy});
    end
  endtask

  initial begin
    int rises[$];
    int fall0;
    int first1;
    logic prev;
    bus.btnIn = '0;

    // Reset state
    doReset();
    chk("rst.flag", 0, bus.OffsetFlag, 4'b0000);
    chk("rst.lvl", 0, bus.btnLevel, 4'b0000);
    chk("rst.busy", 0, {3'b0, bus.busy}, 4'b0000);

    // Clean press on right button
    vq.delete();
    for (int n = 0; n < 6; n++) add(4'b0010, 4'b0000, 4'b0000, 1'b0);
    add(4'b0010, 4'b0000, 4'b0010, 1'b0);
    add(4'b0010, 4'b0000, 4'b0010, 1'b0);
    add(4'b0010, 4'b0010, 4'b0010, 1'b1);
    add(4'b0010, 4'b0010, 4'b0010, 1'b1);
    add(4'b0000, 4'b0000, 4'b0010, 1'b1);
    add(4'b0000, 4'b0000, 4'b0010, 1'b1);
    add(4'b0000, 4'b0000, 4'b0010, 1'b0);
    add(4'b0000, 4'b0000, 4'b0010, 1'b0);
    runTable("press");

    // Simultaneous left + up, round-robin order
    doReset();
    vq.delete();
    for (int n = 0; n < 6; n++) add(4'b0101, 4'b0000, 4'b0000, 1'b0);
    add(4'b0101, 4'b0000, 4'b0101, 1'b0);
    add(4'b0101, 4'b0000, 4'b0101, 1'b0);
    add(4'b0101, 4'b0001, 4'b0101, 1'b1);
    add(4'b0101, 4'b0001, 4'b0101, 1'b1);
    add(4'b0000, 4'b0000, 4'b0101, 1'b1);
    add(4'b0000, 4'b0000, 4'b0101, 1'b1);
    add(4'b0000, 4'b0000, 4'b0101, 1'b0);
    add(4'b0000, 4'b0100, 4'b0101, 1'b1);
    add(4'b0000, 4'b0100, 4'b0101, 1'b1);
    add(4'b0000, 4'b0000, 4'b0101, 1'b1);
    add(4'b0000, 4'b0000, 4'b0000, 1'b1);
    runTable("rr");

    // Reset asserted mid-pulse, then idle after release
    doReset();
    bus.btnIn = 4'b0010;
    for (int n = 0; n <= 8; n++) tick();
    chk("rstmid.pre", 8, bus.OffsetFlag, 4'b0010);
    reset = 1'b0;
    #1;
    chk("rstmid.flag", 8, bus.OffsetFlag, 4'b0000);
    chk("rstmid.busy", 8, {3'b0, bus.busy}, 4'b0000);
    chk("rstmid.lvl", 8, bus.btnLevel, 4'b0000);
    bus.btnIn = '0;
    #1 reset = 1'b1;
    for (int n = 0; n < 10; n++) begin
      tick();
      chk("rstidle.flag", n, bus.OffsetFlag, 4'b0000);
      chk("rstidle.busy", n, {3'b0, bus.busy}, 4'b0000);
    end

    // Button held through reset gets a fresh edge request
    bus.btnIn = 4'b0010;
    for (int n = 0; n <= 8; n++) tick();
    reset = 1'b0;
    #1;
    chk("rsthold.drop", 8, bus.OffsetFlag, 4'b0000);
    #1 reset = 1'b1;
    for (int n = 0; n < 10; n++) begin
      tick();
      chk("rsthold.flag", n, bus.OffsetFlag,
          (n == 8 || n == 9) ? 4'b0010 : 4'b0000);
    end

    // Bouncing up button never settles
    doReset();
    for (int n = 0; n < 40; n++) begin
      bus.btnIn = (n < 30 && ((n / 3) % 2 == 0)) ? 4'b0100 : 4'b0000;
      tick();
      chk("bounce.lvl", n, bus.btnLevel, 4'b0000);
      chk("bounce.flag", n, bus.OffsetFlag, 4'b0000);
    end

    // Auto-repeat on down button
    doReset();
    prev = 1'b0;
    rises.delete();
    for (int n = 0; n <= 100; n++) begin
      bus.btnIn = (n < 60) ? 4'b1000 : 4'b0000;
      tick();
      if (bus.OffsetFlag[3] && !prev) rises.push_back(n);
      prev = bus.OffsetFlag[3];
      if (n == 65) chk("rep.lvlhi", n, bus.btnLevel, 4'b1000);
      if (n == 66) chk("rep.lvllo", n, bus.btnLevel, 4'b0000);
    end
    begin
      int early[$];
      int late;
      late = 0;
      foreach (rises[i]) begin
        if (rises[i] < 48) early.push_back(rises[i]);
        if (rises[i] >= 67) late++;
      end
      chkInt("rep.count", early.size(), 4);
      if (early.size() == 4) begin
        chkInt("rep.r0", early[0], 8);
        chkInt("rep.r1", early[1], 28);
        chkInt("rep.r2", early[2], 36);
        chkInt("rep.r3", early[3], 44);
      end
      chkInt("rep.afterRelease", late, 0);
    end

    // Opposite-direction conflict on left/right
    doReset();
    fall0  = -1;
    first1 = -1;
    prev   = 1'b0;
    for (int n = 0; n <= 80; n++) begin
      bus.btnIn = (n < 40) ? 4'b0011 : ((n < 75) ? 4'b0010 : 4'b0000);
      tick();
      if (fall0 < 0 && n > 10 && !bus.btnLevel[0]) fall0 = n;
      if (first1 < 0 && bus.OffsetFlag[1]) first1 = n;
      if (n < 67) chk("opp.flag", n, bus.OffsetFlag, 4'b0000);
      if (n == 45) chk("opp.lvl45", n, bus.btnLevel, 4'b0011);
    end
    chkInt("opp.fall0", fall0, 46);
    chkInt("opp.firstRise", first1, fall0 + RD + 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end
endmodule
